fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined RV64 core: owns the program counter, drives the byte address into the combinational instruction memory, and captures the returned 32-bit little-endian word into the IF/ID pipeline register. Supports hazard stalls and branch/jump redirects from EX, which flush the wrong-path instruction. Sits between the hazard/branch logic and the decode stage.

---
 rtl/fetch_stage_pkg.sv | 35 +++
 rtl/fetch_stage_if.sv | 20 ++
 rtl/fetch_stage_if_id_reg.sv | 24 ++
 rtl/fetch_stage.sv | 104 ++++++++++
 tb/tb_fetch_stage.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared core types and constants for the instruction-fetch stage.
// Holds word sizes, the NOP encoding and the fetch state enum.
package fetch_stage_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC  = 64'h0;
    localparam logic [XLEN-1:0] PC_STEP   = 64'd4;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic            valid;
    } if_id_t;

    localparam if_id_t IF_ID_EMPTY = '{
        pc:    64'h0,
        instr: NOP_INSTR,
        valid: 1'b0
    };

    function automatic logic [XLEN-1:0] word_align(
        input logic [XLEN-1:0] addr
    );
        return addr & ~64'h3;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and the external memory.
// The memory returns the word for addr combinationally.
interface fetch_stage_if
    import fetch_stage_pkg::*;
();

    logic [XLEN-1:0] addr;
    logic [ILEN-1:0] instr;

    modport master (
        output addr,
        input  instr
    );

    modport slave (
        input  addr,
        output instr
    );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with hold (stall) and flush (redirect) controls.
// Flush wins over hold so a redirect always squashes the wrong-path slot.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   hold,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= IF_ID_EMPTY;
        end else if (flush) begin
            q <= IF_ID_EMPTY;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC and next-PC mux and feeds the IF/ID register.
// Define FETCH_MISALIGN_CHK_EN to trap misaligned redirects in FAULT.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_target,
    fetch_stage_if.master    imem,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  if_id_pc,
    output logic [ILEN-1:0]  if_id_instr,
    output logic             if_id_valid
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic             fetch_fault
`endif
);

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] target;
    logic            hold;
    logic            flush;
    if_id_t          id_d;
    if_id_t          id_q;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misaligned;

    assign target     = redirect_target;
    assign misaligned = |redirect_target[1:0];
`else
    assign target = word_align(redirect_target);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hold    = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            RUN: begin
                if (redirect) begin
                    pc_d  = target;
                    flush = 1'b1;
`ifdef FETCH_MISALIGN_CHK_EN
                    if (misaligned) begin
                        state_d = FAULT;
                    end
`endif
                end else if (stall) begin
                    hold = 1'b1;
                end else begin
                    pc_d = pc_q + PC_STEP;
                end
            end
            // Parked at the bad target; only reset leaves this state.
            FAULT: begin
                flush = 1'b1;
            end
        endcase
    end

    assign id_d = '{
        pc:    pc_q,
        instr: imem.instr,
        valid: 1'b1
    };

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .reset (reset),
        .hold  (hold),
        .flush (flush),
        .d     (id_d),
        .q     (id_q)
    );

    assign imem.addr   = pc_q;
    assign pc          = pc_q;
    assign if_id_pc    = id_q.pc;
    assign if_id_instr = id_q.instr;
    assign if_id_valid = id_q.valid;

`ifdef FETCH_MISALIGN_CHK_EN
    assign fetch_fault = (state_q == FAULT);
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus randomized bench for fetch_stage against a reference model.
// Honours FETCH_MISALIGN_CHK_EN the same way the design does.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

`ifdef FETCH_MISALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_target = 64'h0;
    logic [63:0] pc;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        fetch_fault;
`endif

    fetch_stage_if imem ();

    fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem            (imem),
        .pc              (pc),
        .if_id_pc        (if_id_pc),
        .if_id_instr     (if_id_instr),
        .if_id_valid     (if_id_valid)
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        .fetch_fault     (fetch_fault)
`endif
    );

    always #5 clk = ~clk;

    // 256-byte memory image, mirrored across the whole address space
    logic [7:0] mem [256];

    function automatic logic [31:0] word_at(input logic [63:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {mem[b + 8'd3], mem[b + 8'd2], mem[b + 8'd1], mem[b]};
    endfunction

    always_comb imem.instr = word_at(imem.addr);

    int checks = 0;
    int failures = 0;

    logic [63:0] m_pc;
    logic [63:0] m_ipc;
    logic [31:0] m_instr;
    logic        m_valid;
    logic        m_fault;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".pc"}, pc, m_pc);
        chk({ctx, ".imem_addr"}, imem.addr, m_pc);
        chk({ctx, ".if_id_pc"}, if_id_pc, m_ipc);
        chk({ctx, ".if_id_instr"}, {32'h0, if_id_instr}, {32'h0, m_instr});
        chk({ctx, ".if_id_valid"}, {63'h0, if_id_valid}, {63'h0, m_valid});
`ifdef FETCH_MISALIGN_CHK_EN
        chk({ctx, ".fetch_fault"}, {63'h0, fetch_fault}, {63'h0, m_fault});
`endif
    endtask

    task automatic model_reset();
        m_pc    = 64'h0;
        m_ipc   = 64'h0;
        m_instr = 32'h13;
        m_valid = 1'b0;
        m_fault = 1'b0;
    endtask

    task automatic bubble();
        m_ipc   = 64'h0;
        m_instr = 32'h13;
        m_valid = 1'b0;
    endtask

    task automatic model_step(input bit s, input bit r, input logic [63:0] t);
        if (m_fault) begin
            bubble();
        end else if (r) begin
            bubble();
            if (CHK) begin
                m_pc = t;
                m_fault = (t % 4) != 0;
            end else begin
                m_pc = t - (t % 4);
            end
        end else if (!s) begin
            m_ipc   = m_pc;
            m_instr = word_at(m_pc);
            m_valid = 1'b1;
            m_pc    = m_pc + 64'd4;
        end
    endtask

    task automatic cycle(input string ctx, input bit s, input bit r,
                         input logic [63:0] t);
        stall = s;
        redirect = r;
        redirect_target = t;
        model_step(s, r, t);
        @(posedge clk);
        #1;
        check_all(ctx);
    endtask

    task automatic async_reset(input string ctx);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all(ctx);
        @(posedge clk);
        #1;
        check_all({ctx, "_held"});
        reset = 1'b0;
    endtask

    initial begin
        logic [63:0] t;
        bit          s;
        bit          r;

        foreach (mem[i]) mem[i] = 8'($urandom);
        mem[0] = 8'h83;
        mem[1] = 8'h34;
        mem[2] = 8'h85;
        mem[3] = 8'h02;

        #1;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("reset_async");
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_held");
        reset = 1'b0;

        cycle("first", 1'b0, 1'b0, 64'h0);
        chk("first_instr", {32'h0, if_id_instr}, 64'h0285_3483);
        chk("first_pc", pc, 64'h4);

        cycle("adv8", 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 3; i++) begin
            cycle("stall", 1'b1, 1'b0, 64'h0);
            chk("stall_pc", pc, 64'h8);
        end
        cycle("unstall", 1'b0, 1'b0, 64'h0);
        chk("unstall_ipc", if_id_pc, 64'h8);

        cycle("redir", 1'b0, 1'b1, 64'h10);
        chk("redir_pc", pc, 64'h10);
        chk("redir_instr", {32'h0, if_id_instr}, 64'h13);
        cycle("redir_land", 1'b0, 1'b0, 64'h0);
        chk("redir_land_ipc", if_id_pc, 64'h10);

        cycle("redir_stall", 1'b1, 1'b1, 64'h20);
        chk("redir_stall_pc", pc, 64'h20);
        chk("redir_stall_valid", {63'h0, if_id_valid}, 64'h0);

        cycle("wrap_set", 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle("wrap_step", 1'b0, 1'b0, 64'h0);
        chk("wrap_pc", pc, 64'h0);
        cycle("wrap_after", 1'b0, 1'b0, 64'h0);

        for (int i = 0; i < 300; i++) begin
            s = $urandom_range(9) < 3;
            r = $urandom_range(9) < 2;
            t = {56'h0, 8'($urandom)};
            if ($urandom_range(7) == 0) t[63:32] = 32'($urandom);
            if (CHK) t[1:0] = 2'b00;
            cycle("rand", s, r, t);
        end

        async_reset("midrun_reset");
        cycle("post_reset", 1'b0, 1'b0, 64'h0);

        cycle("misalign", 1'b0, 1'b1, 64'h6);
        if (CHK) begin
            chk("misalign_pc", pc, 64'h6);
            for (int i = 0; i < 3; i++) begin
                cycle("fault_hold", $urandom_range(1) == 1, 1'b0, 64'h0);
            end
            cycle("fault_redir", 1'b0, 1'b1, 64'h40);
            chk("fault_redir_pc", pc, 64'h6);
            async_reset("fault_clear");
            cycle("fault_recover", 1'b0, 1'b0, 64'h0);
        end else begin
            chk("misalign_pc", pc, 64'h4);
            cycle("misalign_land", 1'b0, 1'b0, 64'h0);
            chk("misalign_ipc", if_id_pc, 64'h4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
